// File: rtl/cpu_defs.sv
// Shared datapath definitions: address width, control-flow opcodes and
// PC-source mux select encodings used across the CPU.
package cpu_defs;

    localparam int ADDR_W = 12;

    localparam logic [4:0] OP_JMP  = 5'b11100;
    localparam logic [4:0] OP_CALL = 5'b11101;
    localparam logic [5:0] OP_RET  = 6'b111100;

    typedef enum logic [1:0] {
        SEL_PC1 = 2'b00,
        SEL_BR  = 2'b01,
        SEL_JMP = 2'b10
    } selectAdress_e;

endpackage

// File: rtl/stack_ram.sv
// Register file backing the return-address stack: one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module stack_ram #(
    parameter int ADDR_W = cpu_defs::ADDR_W,
    parameter int DEPTH  = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    // Write the selected entry on the rising edge when enabled.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Hardware return-address stack. CALL pushes PC+1, RET pops and sees the
// top entry in the same cycle through a combinational read path.
module return_addr_stack
    import cpu_defs::*;
#(
    parameter int ADDR_W = cpu_defs::ADDR_W,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              init_signal,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] ret_addr,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] IDX_ONE    = PTR_W'(1);

    logic [PTR_W:0]    nextCount;
    logic [PTR_W-1:0]  topIdx;
    logic [PTR_W-1:0]  writeIdx;
    logic              writeEn;
    logic              setOverflow;
    logic              setUnderflow;
    logic [ADDR_W-1:0] readData;

    assign empty  = (count == '0);
    assign full   = (count == FULL_COUNT);
    // At count == DEPTH the low bits are zero, so subtracting one wraps to DEPTH-1.
    assign topIdx = count[PTR_W-1:0] - IDX_ONE;

    // Decode the push/pop strobes into a write, a new count and flag sets.
    always_comb begin
        nextCount    = count;
        writeEn      = 1'b0;
        writeIdx     = count[PTR_W-1:0];
        setOverflow  = 1'b0;
        setUnderflow = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    writeEn   = 1'b1;
                    nextCount = count + COUNT_ONE;
                end else begin
                    setOverflow = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    nextCount = count - COUNT_ONE;
                end else begin
                    setUnderflow = 1'b1;
                end
            end
            2'b11: begin
                writeEn = 1'b1;
                if (!empty) begin
                    writeIdx = topIdx;
                end else begin
                    nextCount = count + COUNT_ONE;
                end
            end
            default: begin
                nextCount = count;
            end
        endcase
    end

    // Count and sticky error flags; reset overrides any strobe that cycle.
    always_ff @(posedge clock) begin
        if (init_signal) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count <= nextCount;
            if (setOverflow) begin
                overflow <= 1'b1;
            end
            if (setUnderflow) begin
                underflow <= 1'b1;
            end
        end
    end

    stack_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_stackRam (
        .clock (clock),
        .we    (writeEn && !init_signal),
        .waddr (writeIdx),
        .wdata (push_addr),
        .raddr (topIdx),
        .rdata (readData)
    );

    assign ret_addr = empty ? '0 : readData;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack: stimulus queues hand-computed
// expected outputs, a monitor pops and compares them on each falling edge.
module tb_return_addr_stack;

    logic        clock;
    logic        init_signal;
    logic        push;
    logic        pop;
    logic [11:0] push_addr;
    logic [11:0] ret_addr;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    typedef struct {
        string       name;
        logic [11:0] ret;
        logic [3:0]  cnt;
        logic        ov;
        logic        un;
    } expect_t;

    expect_t expQ[$];
    int checks   = 0;
    int failures = 0;

    return_addr_stack dut (
        .clock       (clock),
        .init_signal (init_signal),
        .push        (push),
        .pop         (pop),
        .push_addr   (push_addr),
        .ret_addr    (ret_addr),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input string field,
                               input logic [11:0] actual, input logic [11:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected before the edge.
    task automatic applyStimulus(input string name, input logic initV, input logic pushV,
                                 input logic popV, input logic [11:0] addr,
                                 input logic [11:0] expRet, input logic [3:0] expCnt,
                                 input logic expOv, input logic expUn);
        expect_t e;
        init_signal = initV;
        push        = pushV;
        pop         = popV;
        push_addr   = addr;
        e.name = name;
        e.ret  = expRet;
        e.cnt  = expCnt;
        e.ov   = expOv;
        e.un   = expUn;
        expQ.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Monitor: outputs are combinational, so every falling edge presents a result.
    initial begin
        expect_t e;
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.name, "ret_addr",  ret_addr,         e.ret);
                checkOutput(e.name, "count",     {8'h0, count},    {8'h0, e.cnt});
                checkOutput(e.name, "empty",     {11'h0, empty},   {11'h0, (e.cnt == 4'd0)});
                checkOutput(e.name, "full",      {11'h0, full},    {11'h0, (e.cnt == 4'd8)});
                checkOutput(e.name, "overflow",  {11'h0, overflow},  {11'h0, e.ov});
                checkOutput(e.name, "underflow", {11'h0, underflow}, {11'h0, e.un});
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        init_signal = 1'b1;
        push        = 1'b0;
        pop         = 1'b0;
        push_addr   = 12'h000;
        repeat (2) @(posedge clock);
        #1;

        // Reset state, then three pushes and three pops.
        applyStimulus("rst_idle", 0, 0, 0, 12'h000, 12'h000, 4'd0, 0, 0);
        applyStimulus("push10",   0, 1, 0, 12'h010, 12'h000, 4'd0, 0, 0);
        applyStimulus("push20",   0, 1, 0, 12'h020, 12'h010, 4'd1, 0, 0);
        applyStimulus("push30",   0, 1, 0, 12'h030, 12'h020, 4'd2, 0, 0);
        applyStimulus("top30",    0, 0, 0, 12'h000, 12'h030, 4'd3, 0, 0);
        applyStimulus("pop30",    0, 0, 1, 12'h000, 12'h030, 4'd3, 0, 0);
        applyStimulus("pop20",    0, 0, 1, 12'h000, 12'h020, 4'd2, 0, 0);
        applyStimulus("pop10",    0, 0, 1, 12'h000, 12'h010, 4'd1, 0, 0);
        applyStimulus("drained",  0, 0, 0, 12'h000, 12'h000, 4'd0, 0, 0);

        // Fill past capacity: nine pushes into eight entries.
        for (int i = 0; i < 9; i++) begin
            applyStimulus($sformatf("fill%0d", i), 0, 1, 0, 12'h100 + 12'(i),
                          (i == 0) ? 12'h000 : 12'h100 + 12'(i - 1),
                          (i > 8) ? 4'd8 : 4'(i), 0, 0);
        end
        applyStimulus("full_ov", 0, 0, 0, 12'h000, 12'h107, 4'd8, 1, 0);
        for (int j = 0; j < 8; j++) begin
            applyStimulus($sformatf("unfill%0d", j), 0, 0, 1, 12'h000,
                          12'h107 - 12'(j), 4'(8 - j), 1, 0);
        end
        applyStimulus("empty_ov", 0, 0, 0, 12'h000, 12'h000, 4'd0, 1, 0);
        applyStimulus("reset1",   1, 0, 0, 12'h000, 12'h000, 4'd0, 1, 0);
        applyStimulus("cleared1", 0, 0, 0, 12'h000, 12'h000, 4'd0, 0, 0);

        // Underflow is sticky through later pushes.
        applyStimulus("pop_empty", 0, 0, 1, 12'h000, 12'h000, 4'd0, 0, 0);
        applyStimulus("un_set",    0, 1, 0, 12'h055, 12'h000, 4'd0, 0, 1);
        applyStimulus("un_hold1",  0, 1, 0, 12'h0AA, 12'h055, 4'd1, 0, 1);
        applyStimulus("un_hold2",  0, 0, 0, 12'h000, 12'h0AA, 4'd2, 0, 1);

        // Simultaneous push and pop replaces the top entry.
        applyStimulus("replace",   0, 1, 1, 12'h0BB, 12'h0AA, 4'd2, 0, 1);
        applyStimulus("replaced",  0, 0, 0, 12'h000, 12'h0BB, 4'd2, 0, 1);
        applyStimulus("reset2",    1, 0, 0, 12'h000, 12'h0BB, 4'd2, 0, 1);
        applyStimulus("cleared2",  0, 1, 1, 12'h0CC, 12'h000, 4'd0, 0, 0);
        applyStimulus("pp_empty",  0, 0, 0, 12'h000, 12'h0CC, 4'd1, 0, 0);

        // Reset wins over a push issued in the same cycle.
        applyStimulus("pushD1",    0, 1, 0, 12'h0D1, 12'h0CC, 4'd1, 0, 0);
        applyStimulus("pushD2",    0, 1, 0, 12'h0D2, 12'h0D1, 4'd2, 0, 0);
        applyStimulus("pushD3",    0, 1, 0, 12'h0D3, 12'h0D2, 4'd3, 0, 0);
        applyStimulus("pushD4",    0, 1, 0, 12'h0D4, 12'h0D3, 4'd4, 0, 0);
        applyStimulus("rst_push",  1, 1, 0, 12'h0EE, 12'h0D4, 4'd5, 0, 0);
        applyStimulus("after_rst", 0, 0, 0, 12'h000, 12'h000, 4'd0, 0, 0);
        applyStimulus("pushF0",    0, 1, 0, 12'h0F0, 12'h000, 4'd0, 0, 0);
        applyStimulus("topF0",     0, 0, 0, 12'h000, 12'h0F0, 4'd1, 0, 0);

        repeat (2) @(posedge clock);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain actual=%0d expected=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
